// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   Issue/return stage in front of the 16-bit sequential divider.
//   Accepts divide requests over a valid/ready handshake, drives the divider
//   operand bus, waits for the divider's done handshake (low, then high) and
//   returns quotient/remainder over a valid/ack handshake. Divide-by-zero and
//   repeats of the last divided operand pair are answered locally, because the
//   divider never restarts when its operand bus does not change.
//
// Parameters
//   TIMEOUT_CYC  max cycles spent waiting on the divider before aborting (>= 1)
//   SETTLE_CYC   cycles the operand bus is held stable before watching done (>= 1)
//
// Ports
//   inp_clk, inp_rst            clock, synchronous active-high reset
//   inp_valid / out_ready       request handshake; inp_a / inp_b sampled on accept
//   out_valid / inp_ack         response handshake; response held until ack
//   out_quotient/out_remainder  response data
//   out_div_zero / out_err      divide-by-zero / timeout-abort flags
//   out_div_a / out_div_b       operand bus to the divider
//   inp_div_done                divider done flag
//   inp_div_result              divider result {quotient, remainder}
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned SETTLE_CYC  = 2
) (
    input  logic        inp_clk,
    input  logic        inp_rst,
    input  logic        inp_valid,
    output logic        out_ready,
    input  logic [15:0] inp_a,
    input  logic [15:0] inp_b,
    output logic        out_valid,
    input  logic        inp_ack,
    output logic [15:0] out_quotient,
    output logic [15:0] out_remainder,
    output logic        out_div_zero,
    output logic        out_err,
    output logic [15:0] out_div_a,
    output logic [15:0] out_div_b,
    input  logic        inp_div_done,
    input  logic [31:0] inp_div_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_HIT,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RESP
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] a_q, b_q;
    logic        cache_valid;
    logic [15:0] cache_quot, cache_rem;

    // One-cycle strobes from the FSM into the datapath.
    logic accept;
    logic drive_bus;
    logic ld_zero;
    logic ld_hit;
    logic ld_result;
    logic ld_timeout;
    logic do_ack;
    logic tmo_hit;

    assign out_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_RESP);

    // The counter is shared: LAUNCH uses it for settling, the wait states
    // for the timeout. Using >= lets a WAIT_LOW->WAIT_HIGH step on the last
    // allowed cycle still time out on the following cycle.
    assign tmo_hit = (cnt_q >= TMO_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        drive_bus  = 1'b0;
        ld_zero    = 1'b0;
        ld_hit     = 1'b0;
        ld_result  = 1'b0;
        ld_timeout = 1'b0;
        do_ack     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inp_valid) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    if (inp_b == 16'd0) begin
                        state_d = S_ZERO;
                    end else if (cache_valid && (inp_a == out_div_a) && (inp_b == out_div_b)) begin
                        state_d = S_HIT;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end

            S_ZERO: begin
                ld_zero = 1'b1;
                state_d = S_RESP;
            end

            S_HIT: begin
                ld_hit  = 1'b1;
                state_d = S_RESP;
            end

            // First LAUNCH cycle puts a_q/b_q on the bus; the bus is then
            // stable for SETTLE_CYC further cycles before WAIT_LOW.
            S_LAUNCH: begin
                if (cnt_q == 16'd0) begin
                    drive_bus = 1'b1;
                end
                if (cnt_q >= SETTLE_LAST) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_WAIT_LOW: begin
                cnt_d = cnt_q + 16'd1;
                if (!inp_div_done) begin
                    state_d = S_WAIT_HIGH;
                end else if (tmo_hit) begin
                    ld_timeout = 1'b1;
                    state_d    = S_RESP;
                end
            end

            S_WAIT_HIGH: begin
                cnt_d = cnt_q + 16'd1;
                if (inp_div_done) begin
                    ld_result = 1'b1;
                    state_d   = S_RESP;
                end else if (tmo_hit) begin
                    ld_timeout = 1'b1;
                    state_d    = S_RESP;
                end
            end

            S_RESP: begin
                if (inp_ack) begin
                    do_ack  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_div_zero  <= 1'b0;
            out_err       <= 1'b0;
            out_div_a     <= '0;
            out_div_b     <= '0;
            cache_valid   <= 1'b0;
            cache_quot    <= '0;
            cache_rem     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (accept) begin
                a_q <= inp_a;
                b_q <= inp_b;
            end

            // The operand bus only ever moves here, so an unchanged bus
            // always matches the cached result.
            if (drive_bus) begin
                out_div_a <= a_q;
                out_div_b <= b_q;
            end

            if (ld_zero) begin
                out_quotient  <= 16'hFFFF;
                out_remainder <= a_q;
                out_div_zero  <= 1'b1;
                out_err       <= 1'b0;
            end

            if (ld_hit) begin
                out_quotient  <= cache_quot;
                out_remainder <= cache_rem;
                out_div_zero  <= 1'b0;
                out_err       <= 1'b0;
            end

            if (ld_result) begin
                out_quotient  <= inp_div_result[31:16];
                out_remainder <= inp_div_result[15:0];
                out_div_zero  <= 1'b0;
                out_err       <= 1'b0;
                cache_quot    <= inp_div_result[31:16];
                cache_rem     <= inp_div_result[15:0];
                cache_valid   <= 1'b1;
            end

            if (ld_timeout) begin
                out_quotient  <= '0;
                out_remainder <= '0;
                out_div_zero  <= 1'b0;
                out_err       <= 1'b1;
                cache_valid   <= 1'b0;
            end

            if (do_ack) begin
                out_div_zero <= 1'b0;
                out_err      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inp_valid = 1'b0;
    logic        out_ready;
    logic [15:0] inp_a = '0;
    logic [15:0] inp_b = '0;
    logic        out_valid;
    logic        inp_ack = 1'b0;
    logic [15:0] out_quotient;
    logic [15:0] out_remainder;
    logic        out_div_zero;
    logic        out_err;
    logic [15:0] out_div_a;
    logic [15:0] out_div_b;
    logic        div_done = 1'b1;
    logic [31:0] div_result = '0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TIMEOUT_CYC(64), .SETTLE_CYC(2)) dut (
        .inp_clk        (clk),
        .inp_rst        (rst),
        .inp_valid      (inp_valid),
        .out_ready      (out_ready),
        .inp_a          (inp_a),
        .inp_b          (inp_b),
        .out_valid      (out_valid),
        .inp_ack        (inp_ack),
        .out_quotient   (out_quotient),
        .out_remainder  (out_remainder),
        .out_div_zero   (out_div_zero),
        .out_err        (out_err),
        .out_div_a      (out_div_a),
        .out_div_b      (out_div_b),
        .inp_div_done   (div_done),
        .inp_div_result (div_result)
    );

    // Behavioural divider: restarts whenever its operand bus changes,
    // drops done, shows junk on the result bus while busy, then raises done.
    logic        force_done = 1'b0;
    logic [31:0] bus_prev = '0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    int unsigned busy_cnt = 0;

    always @(posedge clk) begin
        if (force_done) begin
            div_done <= 1'b1;
            busy_cnt <= 0;
            bus_prev <= {out_div_a, out_div_b};
        end else if ({out_div_a, out_div_b} != bus_prev) begin
            bus_prev   <= {out_div_a, out_div_b};
            op_a       <= out_div_a;
            op_b       <= out_div_b;
            div_done   <= 1'b0;
            busy_cnt   <= 4;
            div_result <= $urandom;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            div_done <= 1'b1;
            if (op_b == 16'd0) div_result <= {16'hFFFF, op_a};
            else               div_result <= {op_a / op_b, op_a % op_b};
        end else if (busy_cnt != 0) begin
            busy_cnt   <= busy_cnt - 1;
            div_result <= $urandom;
        end
    end

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r,
                                input logic dz, input logic err);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.err = err;
        return e;
    endfunction

    task automatic do_req(input logic [15:0] a, input logic [15:0] b, input exp_t e);
        int n = 0;
        while (!out_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_ready) check_val("ready_wait", 0, 1);
        inp_a     = a;
        inp_b     = b;
        inp_valid = 1'b1;
        @(negedge clk);
        inp_valid = 1'b0;
        sb.push_back(e);
    endtask

    // Returns the number of negedges from the end of do_req until out_valid.
    task automatic get_resp(input string tag, output int lat);
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            check_val({tag, "_resp_wait"}, 0, 1);
        end else begin
            check_val({tag, "_q"},   out_quotient,  e.q);
            check_val({tag, "_r"},   out_remainder, e.r);
            check_val({tag, "_dz"},  out_div_zero,  e.dz);
            check_val({tag, "_err"}, out_err,       e.err);
            inp_ack = 1'b1;
            @(negedge clk);
            inp_ack = 1'b0;
            check_val({tag, "_ack_valid"}, out_valid, 0);
            check_val({tag, "_ack_ready"}, out_ready, 1);
        end
    endtask

    initial begin
        int   lat;
        exp_t e;
        logic [15:0] pa [4] = '{16'd65535, 16'd5, 16'd0, 16'd40000};
        logic [15:0] pb [4] = '{16'd1,     16'd9, 16'd3, 16'd255};
        logic [15:0] pq [4] = '{16'd65535, 16'd0, 16'd0, 16'd156};
        logic [15:0] pr [4] = '{16'd0,     16'd5, 16'd0, 16'd220};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_ready", out_ready, 1);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_q",     out_quotient, 0);
        check_val("rst_r",     out_remainder, 0);
        check_val("rst_flags", {out_div_zero, out_err}, 0);
        check_val("rst_bus",   {out_div_a, out_div_b}, 0);

        // Fresh launch.
        do_req(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0));
        get_resp("launch", lat);
        check_val("launch_slow", lat > 2, 1);

        // Identical repeat answered from the cache two cycles after accept.
        do_req(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0));
        get_resp("hit", lat);
        check_val("hit_lat", lat, 1);
        check_val("hit_bus", {out_div_a, out_div_b}, {16'd100, 16'd7});

        // Divide by zero leaves the bus alone.
        do_req(16'd1234, 16'd0, mk(16'hFFFF, 16'd1234, 1'b1, 1'b0));
        get_resp("dz", lat);
        check_val("dz_lat", lat, 1);
        check_val("dz_bus", {out_div_a, out_div_b}, {16'd100, 16'd7});

        for (int unsigned i = 0; i < 4; i++) begin
            do_req(pa[i], pb[i], mk(pq[i], pr[i], 1'b0, 1'b0));
            get_resp("pat", lat);
        end

        // Held response: stable, not ready, extra requests ignored.
        do_req(16'd40000, 16'd255, mk(16'd156, 16'd220, 1'b0, 1'b0));
        @(negedge clk);
        inp_a     = 16'd1;
        inp_b     = 16'd1;
        inp_valid = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("hold_ready", out_ready, 0);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_qr", {out_quotient, out_remainder}, {sb[0].q, sb[0].r});
        end
        inp_valid = 1'b0;
        get_resp("hold", lat);
        check_val("hold_bus", {out_div_a, out_div_b}, {16'd40000, 16'd255});

        // Divider stuck done: timeout, then the same operands relaunch.
        force_done = 1'b1;
        do_req(16'd300, 16'd17, mk(16'd0, 16'd0, 1'b0, 1'b1));
        get_resp("tmo", lat);
        check_val("tmo_slow", lat > 60, 1);
        do_req(16'd300, 16'd17, mk(16'd0, 16'd0, 1'b0, 1'b1));
        get_resp("relaunch", lat);
        check_val("relaunch_no_hit", lat > 60, 1);
        force_done = 1'b0;
        @(negedge clk);

        // Reset while waiting for done to rise.
        do_req(16'd7, 16'd2, mk(16'd3, 16'd1, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = sb.pop_front();
        check_val("mid_rst_ready", out_ready, 1);
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_bus", {out_div_a, out_div_b}, 0);
        repeat (8) @(negedge clk);
        check_val("mid_rst_idle", {out_valid, out_ready}, 2'b01);

        do_req(16'd7, 16'd2, mk(16'd3, 16'd1, 1'b0, 1'b0));
        get_resp("after_rst", lat);
        check_val("after_rst_slow", lat > 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
